// File: rtl/rshift_seq.sv
// Sequential right shifter: one bit per clock, logical or arithmetic fill,
// with a sticky flag collecting every bit shifted out of the LSB.
// Valid/ready handshake on both sides; one operand in flight at a time.
module rshift_seq #(
    parameter int DATA_W = 18,
    parameter int SH_W   = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] entrada,
    input  logic [SH_W-1:0]   sh_amt,
    input  logic              arith,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] saida,
    output logic              lost
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] count;
    logic             fill;
    logic [CNT_W-1:0] start_cnt;

    // Shift distances at or beyond the word width all behave like a full-width shift
    always_comb begin
        start_cnt = CNT_W'(sh_amt);
        if (int'(sh_amt) >= DATA_W)
            start_cnt = CNT_W'(DATA_W);
    end

    // Control FSM plus datapath; saida doubles as the working shift register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            count     <= '0;
            fill      <= 1'b0;
            saida     <= '0;
            lost      <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        saida    <= entrada;
                        fill     <= arith & entrada[DATA_W-1];
                        lost     <= 1'b0;
                        count    <= start_cnt;
                        in_ready <= 1'b0;
                        if (start_cnt == '0) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                        end else begin
                            state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    saida <= {fill, saida[DATA_W-1:1]};
                    lost  <= lost | saida[0];
                    count <= count - 1'b1;
                    // count is never zero here; the last shift lands us in DONE
                    if (count == CNT_W'(1)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule
